mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter for the single unified instruction/data memory of the multicycle CPU. It shares that memory between the CPU datapath and an auxiliary master (program loader / debug port). It issues at most one access per cycle, routes fixed-latency read data back to the issuing requester, and supports a bounded locked burst for the auxiliary master. The CPU controller holds `pcen`, `irwrite` and `regwrite` while `cpu_stall` is high.

## Interface
- `AW`, 16, address width
- `DW`, 16, data width
- `MEM_LAT`, 1, cycles from issue (`mem_en` high) to valid `mem_rdata`; legal range 1..4
- `MAX_BURST`, 4, maximum consecutive aux grants under `aux_lock` while the CPU is requesting; legal range 1..15

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low; low clears all state immediately
- `cpu_req`  in  1  CPU access request; held with address/data stable until granted
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_gnt`  out  1  access issued this cycle for the CPU
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`
- `cpu_rvalid`  out  1  read data for the CPU is valid this cycle
- `cpu_rdata`  out  DW  CPU read data
- `aux_req`, `aux_we`, `aux_addr`, `aux_wdata`  in  1/1/AW/DW  auxiliary request; same rules as the CPU
- `aux_lock`  in  1  aux requests burst ownership; sampled with `aux_req`
- `aux_gnt`, `aux_rvalid`, `aux_rdata`  out  1/1/DW  same meaning as the CPU outputs
- `mem_en`, `mem_we`  out  1  memory access strobe / write enable
- `mem_addr`, `mem_wdata`  out  AW/DW  muxed address and write data
- `mem_rdata`  in  DW  memory read data, valid `MEM_LAT` cycles after the read issue

## Operation
- Grant is combinational from the requests and the registered state. At most one of `cpu_gnt`/`aux_gnt` is high. `mem_en = cpu_gnt | aux_gnt`. `mem_we`, `mem_addr` and `mem_wdata` come from the granted requester; they are 0 when idle.
- State register `owner` takes one of four states:
  - IDLE: no grant last cycle
  - CPU: last grant to the CPU
  - AUX: last grant to aux, unlocked
  - LOCK: last grant to aux with `aux_lock`
- 4-bit `burst_cnt` counts consecutive locked aux grants.
- Single requester: that requester is granted every cycle.
- Both requesting, by state:
  - IDLE or AUX: grant the CPU.
  - CPU: grant aux (round-robin).
  - LOCK with `aux_lock` high and `burst_cnt < MAX_BURST`: grant aux.
  - Otherwise: grant the CPU.
- Transitions:
  - CPU grant: next state CPU, `burst_cnt` to 0.
  - Aux grant with `aux_lock`: next state LOCK, `burst_cnt` to `burst_cnt+1`, saturating at 15.
  - Aux grant without `aux_lock`: next state AUX, `burst_cnt` to 0.
  - No grant: next state IDLE, `burst_cnt` to 0.
- `burst_cnt` increments only while the CPU is also requesting. A locked aux burst against an idle CPU is unlimited and holds the count at 0.
- Return path: a `MEM_LAT`-deep shift register of tags {valid, is_cpu} advances every cycle. A tag is pushed for each read issue; writes push an invalid tag. When a valid tag reaches the tail, pulse the matching `*_rvalid` for one cycle and drive its `*_rdata` from `mem_rdata`. The non-matching `*_rdata` holds its last value.
- No backpressure on the return path; requesters always accept `rvalid`.

## Timing
- Reset (async assert, `reset` low): `owner`=CPU, `burst_cnt`=0, tag pipe cleared, `cpu_rdata`=`aux_rdata`=0, both `rvalid`=0. Starting in state CPU makes aux win the first contention after reset. Combinational grant outputs are forced 0 while `reset` is low.
- Reset asserted mid-operation: in-flight reads are dropped and no `rvalid` is produced for them. Requesters re-issue the access.
- Grant latency: 0 cycles for an uncontended request. Worst-case CPU wait is `MAX_BURST` cycles under an aux lock, and 1 cycle otherwise.
- Read latency: `rvalid` rises exactly `MEM_LAT` cycles after the grant cycle. With back-to-back reads, one `rvalid` is produced per cycle.
- Simultaneous: a read granted in cycle N and a write granted in cycle N+1 produce only the read's `rvalid` (at N+`MEM_LAT`).

## Test plan
- Reset, then CPU reads addr 0x0010 with memory model returning 0xBEEF, `MEM_LAT`=1 -> `cpu_gnt`=1 in the same cycle, `cpu_rvalid`=1 and `cpu_rdata`=0xBEEF one cycle later, `aux_rvalid` stays 0.
- Both requesting continuously, no lock, starting from reset -> grants alternate AUX,CPU,AUX,CPU; `cpu_stall` is high on every aux-grant cycle.
- Both requesting, `aux_lock`=1, `MAX_BURST`=4 -> after the first CPU grant, 4 consecutive aux grants, then one CPU grant, then aux resumes; `burst_cnt` never exceeds 4.
- Interleaved read (CPU, 0x0002 returns 0x1234) and write (aux, 0x0003 <- 0x5555) with `MEM_LAT`=3 -> exactly one `cpu_rvalid`, 3 cycles after its grant, carrying 0x1234; no `aux_rvalid`; memory holds 0x5555 at 0x0003.
- Assert `reset` low for 1 cycle with 2 reads in flight -> no `rvalid` pulses afterwards; all outputs are 0 during reset; the first contention after release goes to aux.
- `aux_lock`=1 with `cpu_req`=0 for 20 cycles -> 20 aux grants, `burst_cnt` stays 0; a CPU request then wins within 1 cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester memory port arbiter with locked aux bursts
// and a fixed-latency tagged read return path.
module mem_port_arbiter #(
    parameter int AW        = 16,
    parameter int DW        = 16,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          aux_req,
    input  logic          aux_we,
    input  logic [AW-1:0] aux_addr,
    input  logic [DW-1:0] aux_wdata,
    input  logic          aux_lock,
    output logic          aux_gnt,
    output logic          aux_rvalid,
    output logic [DW-1:0] aux_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_AUX  = 2'd2,
        OWN_LOCK = 2'd3
    } owner_e;

    owner_e              owner_q, owner_d;
    logic [3:0]          burst_cnt_q, burst_cnt_d;
    logic [MEM_LAT-1:0]  tag_vld_q;
    logic [MEM_LAT-1:0]  tag_cpu_q;
    logic [DW-1:0]       cpu_rdata_q;
    logic [DW-1:0]       aux_rdata_q;
    logic                push_vld;
    logic                ret_vld;
    logic                ret_cpu;

    // Grants are held low while reset is asserted, independent of the registered state.
    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (reset) begin
            if (cpu_req && aux_req) begin
                unique case (owner_q)
                    OWN_CPU:  aux_gnt = 1'b1;
                    OWN_LOCK: begin
                        if (aux_lock && (burst_cnt_q < 4'(MAX_BURST))) aux_gnt = 1'b1;
                        else                                          cpu_gnt = 1'b1;
                    end
                    default:  cpu_gnt = 1'b1;
                endcase
            end else begin
                cpu_gnt = cpu_req;
                aux_gnt = aux_req;
            end
        end
    end

    // The burst count only advances while the CPU is actually being held off.
    always_comb begin
        owner_d     = OWN_IDLE;
        burst_cnt_d = 4'd0;
        if (cpu_gnt) begin
            owner_d = OWN_CPU;
        end else if (aux_gnt && aux_lock) begin
            owner_d = OWN_LOCK;
            if (cpu_req) burst_cnt_d = (burst_cnt_q == 4'hF) ? 4'hF : burst_cnt_q + 4'd1;
        end else if (aux_gnt) begin
            owner_d = OWN_AUX;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q     <= OWN_CPU;
            burst_cnt_q <= 4'd0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign cpu_stall = reset & cpu_req & ~cpu_gnt;
    assign mem_en    = cpu_gnt | aux_gnt;
    assign mem_we    = cpu_gnt ? cpu_we    : (aux_gnt ? aux_we    : 1'b0);
    assign mem_addr  = cpu_gnt ? cpu_addr  : (aux_gnt ? aux_addr  : '0);
    assign mem_wdata = cpu_gnt ? cpu_wdata : (aux_gnt ? aux_wdata : '0);

    assign push_vld  = mem_en & ~mem_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_q <= '0;
            tag_cpu_q <= '0;
        end else begin
            tag_vld_q[0] <= push_vld;
            tag_cpu_q[0] <= cpu_gnt;
            for (int i = 1; i < MEM_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_cpu_q[i] <= tag_cpu_q[i-1];
            end
        end
    end

    assign ret_vld    = tag_vld_q[MEM_LAT-1];
    assign ret_cpu    = tag_cpu_q[MEM_LAT-1];
    assign cpu_rvalid = ret_vld & ret_cpu;
    assign aux_rvalid = ret_vld & ~ret_cpu;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign aux_rdata  = aux_rvalid ? mem_rdata : aux_rdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata_q <= '0;
            aux_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
            if (aux_rvalid) aux_rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed bench for mem_port_arbiter
// against a behavioural arbitration/return model.
module tb_mem_port_arbiter;
    localparam int AW        = 16;
    localparam int DW        = 16;
    localparam int MEM_LAT   = 3;
    localparam int MAX_BURST = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          aux_req = 1'b0, aux_we = 1'b0, aux_lock = 1'b0;
    logic [AW-1:0] aux_addr = '0;
    logic [DW-1:0] aux_wdata = '0;
    logic          cpu_gnt, cpu_stall, cpu_rvalid, aux_gnt, aux_rvalid;
    logic [DW-1:0] cpu_rdata, aux_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_lock(aux_lock), .aux_gnt(aux_gnt), .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Memory environment: fixed-latency read pipe, writes land at the issuing edge.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] rd_pipe [MEM_LAT];
    bit            mem_ready = 1'b0;
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 16'h0137) ^ 16'hA5C3;
            mem[2]    <= 16'h1234;
            mem[16]   <= 16'hBEEF;
            mem_ready <= 1'b1;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:0]] <= mem_wdata;
        end
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 16'hDEAD;
    end

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        int          due;
        bit          is_cpu;
        logic [15:0] data;
    } ret_t;

    // Model: m_last 0=no grant, 1=CPU, 2=aux unlocked, 3=aux locked; m_run = locked aux
    // grants in a row that held off a requesting CPU.
    int          m_last = 1, m_run = 0, m_cyc = 0, streak = 0;
    ret_t        m_q[$];
    logic [15:0] m_cpu_rd = '0, m_aux_rd = '0;

    always @(negedge clk) begin : compare
        bit          aw, cw, rv_c, rv_a, rd;
        ret_t        r;
        logic [15:0] ea;
        logic [15:0] ed;
        if (!reset) begin
            chk("rst_cpu_gnt", cpu_gnt, 0);   chk("rst_aux_gnt", aux_gnt, 0);
            chk("rst_stall", cpu_stall, 0);   chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);     chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_cpu_rvalid", cpu_rvalid, 0); chk("rst_aux_rvalid", aux_rvalid, 0);
            chk("rst_cpu_rdata", cpu_rdata, 0);   chk("rst_aux_rdata", aux_rdata, 0);
            m_last = 1; m_run = 0; streak = 0;
            m_q.delete();
            m_cpu_rd = '0; m_aux_rd = '0;
        end else begin
            aw = aux_req && (!cpu_req || m_last == 1 ||
                             (m_last == 3 && aux_lock && m_run < MAX_BURST));
            cw = cpu_req && !aw;
            rv_c = 1'b0; rv_a = 1'b0;
            if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
                r = m_q.pop_front();
                if (r.is_cpu) begin rv_c = 1'b1; m_cpu_rd = r.data; end
                else          begin rv_a = 1'b1; m_aux_rd = r.data; end
            end
            ea = cw ? cpu_addr : (aw ? aux_addr : 16'h0);
            ed = cw ? cpu_wdata : (aw ? aux_wdata : 16'h0);
            chk("cpu_gnt", cpu_gnt, cw);
            chk("aux_gnt", aux_gnt, aw);
            chk("cpu_stall", cpu_stall, cpu_req && !cw);
            chk("mem_en", mem_en, cw || aw);
            chk("mem_we", mem_we, cw ? cpu_we : (aw ? aux_we : 1'b0));
            chk("mem_addr", mem_addr, ea);
            chk("mem_wdata", mem_wdata, ed);
            chk("cpu_rvalid", cpu_rvalid, rv_c);
            chk("aux_rvalid", aux_rvalid, rv_a);
            chk("cpu_rdata", cpu_rdata, m_cpu_rd);
            chk("aux_rdata", aux_rdata, m_aux_rd);
            chk("burst_cnt", dut.burst_cnt_q, 32'(m_run));
            streak = (aux_gnt && cpu_req) ? streak + 1 : 0;
            if (streak > MAX_BURST) chk("cpu_wait_bound", streak, MAX_BURST);
            rd = (cw && !cpu_we) || (aw && !aux_we);
            if (rd) m_q.push_back('{m_cyc + MEM_LAT, cw, mem[ea[7:0]]});
            if (cw)                   begin m_last = 1; m_run = 0; end
            else if (aw && aux_lock)  begin m_last = 3; m_run = cpu_req ? (m_run < 15 ? m_run + 1 : 15) : 0; end
            else if (aw)              begin m_last = 2; m_run = 0; end
            else                      begin m_last = 0; m_run = 0; end
        end
        m_cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        cpu_req = 1'b0; cpu_we = 1'b0; aux_req = 1'b0; aux_we = 1'b0; aux_lock = 1'b0;
    endtask

    task automatic rst_pulse();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        logic [3:0]  alt_pat;
        logic [9:0]  lock_pat;
        bit          cg, ag;
        alt_pat  = 4'b0101;
        lock_pat = 10'b0111101111;
        repeat (3) step();
        reset = 1'b1;

        // CPU read of 0x0010 returns 0xBEEF after MEM_LAT cycles
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        #3 chk("t1_gnt", cpu_gnt, 1);
        step(); cpu_req = 1'b0;
        repeat (MEM_LAT - 1) step();
        #3 chk("t1_rvalid", cpu_rvalid, 1); chk("t1_rdata", cpu_rdata, 16'hBEEF);
        chk("t1_aux_rvalid", aux_rvalid, 0);
        repeat (2) step();

        // Unlocked contention alternates starting with aux
        rst_pulse();
        cpu_req = 1'b1; aux_req = 1'b1; cpu_we = 1'b1; aux_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3 chk("t2_aux_gnt", aux_gnt, alt_pat[i]); chk("t2_stall", cpu_stall, alt_pat[i]);
            step();
        end
        idle_all(); repeat (MEM_LAT + 1) step();

        // Locked contention: bursts of MAX_BURST aux grants
        rst_pulse();
        cpu_req = 1'b1; aux_req = 1'b1; aux_lock = 1'b1; cpu_we = 1'b1; aux_we = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #3 chk("t3_aux_gnt", aux_gnt, lock_pat[i]);
            step();
        end
        idle_all(); repeat (MEM_LAT + 1) step();

        // CPU read then aux write, only the read returns
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0002;
        step(); cpu_req = 1'b0;
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 16'h0003; aux_wdata = 16'h5555;
        #3 chk("t4_aux_gnt", aux_gnt, 1);
        step(); aux_req = 1'b0;
        step();
        #3 chk("t4_rvalid", cpu_rvalid, 1); chk("t4_rdata", cpu_rdata, 16'h1234);
        repeat (3) step();
        chk("t4_mem", mem[3], 16'h5555);

        // Reset with two reads in flight
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        step(); cpu_req = 1'b0;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 16'h0006;
        step();
        reset = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; aux_we = 1'b1;
        #3 chk("t5_gnt", {cpu_gnt, aux_gnt, mem_en, cpu_stall}, 0);
        chk("t5_rv", {cpu_rvalid, aux_rvalid}, 0);
        step(); reset = 1'b1;
        #3 chk("t5_first", aux_gnt, 1);
        step(); idle_all();
        for (int i = 0; i < MEM_LAT + 1; i++) begin
            #3 chk("t5_no_rv", {cpu_rvalid, aux_rvalid}, 0);
            step();
        end

        // Locked aux against an idle CPU is unlimited and keeps the count at zero
        aux_req = 1'b1; aux_lock = 1'b1; aux_we = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #3 chk("t6_aux_gnt", aux_gnt, 1); chk("t6_cnt", dut.burst_cnt_q, 0);
            step();
        end
        cpu_req = 1'b1; cpu_we = 1'b1; aux_lock = 1'b0;
        #3 chk("t6_cpu_wins", cpu_gnt, 1);
        step(); idle_all(); repeat (2) step();

        // Random traffic; a request holds its fields until granted
        cg = 1'b1; ag = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 249) != 0);
            if (!cpu_req || cg) begin
                cpu_req   = ($urandom_range(0, 99) < 60);
                cpu_we    = $urandom_range(0, 1);
                cpu_addr  = 16'($urandom_range(0, 31));
                cpu_wdata = 16'($urandom);
            end
            if (!aux_req || ag) begin
                aux_req   = ($urandom_range(0, 99) < 60);
                aux_we    = $urandom_range(0, 1);
                aux_lock  = ($urandom_range(0, 99) < 50);
                aux_addr  = 16'($urandom_range(0, 31));
                aux_wdata = 16'($urandom);
            end
            #3 cg = cpu_gnt; ag = aux_gnt;
            step();
        end
        reset = 1'b1; idle_all();
        repeat (MEM_LAT + 2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
